rtc_sync_scheduler: RTL

Sequences transactions to the DS-style I2C RTC controller. The controller keeps the emulated OKI clock registers and the battery-backed I2C RTC consistent. It issues a read after reset and then periodically, plus a debounced write-back after CPU writes to the OKI registers. It arbitrates between these two request sources, drives the controller's mutually exclusive read/write handshake, flags stalled transactions, and produces load/store strobes for the OKI register file.

---
 rtl/rtc_sync_scheduler.sv | 128 ++++++++++++
 1 files changed

// File: rtl/rtc_sync_scheduler.sv
// Arbitrates periodic RTC reads and debounced OKI write-backs onto the RTC
// controller's exclusive read/write handshake, with stall detection.
module rtc_sync_scheduler #(
  parameter int unsigned READ_PERIOD = 14000000,
  parameter int unsigned HOLDOFF     = 140000,
  parameter int unsigned TIMEOUT     = 1400000
) (
  input  logic clk14,
  input  logic reset,
  input  logic oki_wr,
  input  logic oki_hold,
  output logic rtc_read,
  output logic rtc_write,
  input  logic rtc_ack,
  output logic rtc_load,
  output logic rtc_stored,
  output logic rtc_valid,
  output logic rtc_busy,
  output logic rtc_timeout,
  input  logic clear_timeout
);

  localparam int unsigned PW = $clog2(READ_PERIOD);
  localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  localparam logic [PW-1:0] PERIOD_LAST = PW'(READ_PERIOD - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLDOFF - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_FIRE     = TW'(TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, READ_REQ, WRITE_REQ} state_t;

  state_t        state;
  logic [PW-1:0] period_cnt;
  logic [HW-1:0] holdoff_cnt;
  logic [TW-1:0] timeout_cnt;
  logic          read_due;
  logic          dirty;
  logic          write_ok;

  always_comb begin
    write_ok = dirty && (holdoff_cnt == '0) && !oki_hold;
  end

  always_ff @(posedge clk14) begin
    if (reset) begin
      state       <= IDLE;
      rtc_read    <= 1'b0;
      rtc_write   <= 1'b0;
      rtc_load    <= 1'b0;
      rtc_stored  <= 1'b0;
      rtc_valid   <= 1'b0;
      rtc_busy    <= 1'b0;
      rtc_timeout <= 1'b0;
      read_due    <= 1'b1;
      dirty       <= 1'b0;
      holdoff_cnt <= '0;
      period_cnt  <= PERIOD_LAST;
      timeout_cnt <= '0;
    end else begin
      rtc_load   <= 1'b0;
      rtc_stored <= 1'b0;

      case (state)
        IDLE: begin
          // Reads wait while dirty so they cannot clobber CPU-written time.
          if (write_ok) begin
            state     <= WRITE_REQ;
            rtc_write <= 1'b1;
            rtc_busy  <= 1'b1;
            dirty     <= 1'b0;
          end else if (read_due && !dirty) begin
            state    <= READ_REQ;
            rtc_read <= 1'b1;
            rtc_busy <= 1'b1;
            read_due <= 1'b0;
          end
        end
        READ_REQ, WRITE_REQ: begin
          if (rtc_ack) begin
            state       <= IDLE;
            rtc_read    <= 1'b0;
            rtc_write   <= 1'b0;
            rtc_busy    <= 1'b0;
            timeout_cnt <= '0;
            if (state == READ_REQ) begin
              rtc_load  <= 1'b1;
              rtc_valid <= 1'b1;
            end else begin
              rtc_stored <= 1'b1;
            end
          end else if (timeout_cnt != TO_LAST) begin
            // Fires only on the step into TIMEOUT-1, so a clear sticks
            // for the rest of a stalled transfer.
            timeout_cnt <= timeout_cnt + 1'b1;
            if (timeout_cnt == TO_FIRE) rtc_timeout <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          rtc_read  <= 1'b0;
          rtc_write <= 1'b0;
          rtc_busy  <= 1'b0;
        end
      endcase

      // Later assignments win: a new period tick or CPU write survives a
      // same-cycle request issue.
      if (period_cnt == '0) begin
        read_due   <= 1'b1;
        period_cnt <= PERIOD_LAST;
      end else begin
        period_cnt <= period_cnt - 1'b1;
      end

      if (oki_wr) begin
        dirty       <= 1'b1;
        holdoff_cnt <= HOLD_LAST;
      end else if (holdoff_cnt != '0) begin
        holdoff_cnt <= holdoff_cnt - 1'b1;
      end

      if (clear_timeout) rtc_timeout <= 1'b0;
    end
  end

endmodule
